// File: rtl/alu_arbiter_pkg.sv
// Shared opcode codes, FSM encoding and opcode legality check for the
// two-requester ALU front end.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request/response channel pair into the shared ALU front end.
// master = requester side, slave = arbiter side.
interface alu_req_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time
// is picked. Purely combinational; the last-grant bit lives in the parent.
module rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters: round-robin accept,
// hold operands for ALU_LAT cycles, then return result/zero/err to the winner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_req_if.slave         req0,
  alu_req_if.slave         req1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam logic [2:0] LAT = 3'(ALU_LAT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_err;

  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_sel;
  logic             w_legal;
  logic             w_rsp_ready;
  logic [WIDTH-1:0] w_req_a;
  logic [WIDTH-1:0] w_req_b;
  logic [3:0]       w_req_op;

  rr_arb2 u_arb (
    .i_valid0     (req0.req_valid),
    .i_valid1     (req1.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_accept    = (r_state == IDLE) && (w_grant != 2'b00);
  assign w_sel       = w_grant[1];
  assign w_req_a     = w_sel ? req1.req_a  : req0.req_a;
  assign w_req_b     = w_sel ? req1.req_b  : req0.req_b;
  assign w_req_op    = w_sel ? req1.req_op : req0.req_op;
  assign w_legal     = is_legal_op(w_req_op);
  assign w_rsp_ready = r_owner ? req1.rsp_ready : req0.rsp_ready;

  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign alu_op = r_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_legal ? EXEC : RESP;
      EXEC:    if (r_cnt == 3'd1) w_state_nxt = RESP;
      RESP:    if (w_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response fields are forced to zero for the non-owner and outside RESP.
  always_comb begin
    req0.req_ready  = 1'b0;
    req1.req_ready  = 1'b0;
    req0.rsp_valid  = 1'b0;
    req1.rsp_valid  = 1'b0;
    req0.rsp_result = '0;
    req1.rsp_result = '0;
    req0.rsp_zero   = 1'b0;
    req1.rsp_zero   = 1'b0;
    req0.rsp_err    = 1'b0;
    req1.rsp_err    = 1'b0;
    if (r_state == IDLE) begin
      req0.req_ready = w_grant[0];
      req1.req_ready = w_grant[1];
    end
    if (r_state == RESP) begin
      if (r_owner) begin
        req1.rsp_valid  = 1'b1;
        req1.rsp_result = r_res;
        req1.rsp_zero   = r_zero;
        req1.rsp_err    = r_err;
      end else begin
        req0.rsp_valid  = 1'b1;
        req0.rsp_result = r_res;
        req0.rsp_zero   = r_zero;
        req0.rsp_err    = r_err;
      end
    end
  end

  // Illegal ops skip the ALU entirely, so its inputs keep their previous value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 3'd0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 4'b0000;
      r_res        <= '0;
      r_zero       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner      <= w_sel;
            r_last_grant <= w_sel;
            if (w_legal) begin
              r_a   <= w_req_a;
              r_b   <= w_req_b;
              r_op  <= w_req_op;
              r_cnt <= LAT;
            end else begin
              r_res  <= '0;
              r_zero <= 1'b0;
              r_err  <= 1'b1;
            end
          end
        end
        EXEC: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_res  <= alu_result;
            r_zero <= alu_zero;
            r_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
